seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_lz_mask.sv | 23 ++
 rtl/seg_scan_driver.sv | 112 +++++++++++
 tb/tb_seg_scan_driver.sv | 135 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and hex font for the multiplexed 7-segment driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_FONT[nib];
    endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero mask: digit i is flagged when nibbles i..top are all zero.
// Digit 0 is never flagged, so a zero value still shows a single "0".
module seg_lz_mask #(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0] hex,
    output logic [NUM_DIGITS-1:0]   blank
);

    logic [NUM_DIGITS-1:0] zero_above;

    always_comb begin
        zero_above = '0;
        zero_above[NUM_DIGITS-1] = (hex[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            zero_above[NUM_DIGITS-1-k] = zero_above[NUM_DIGITS-k]
                                       && (hex[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
        end
        blank    = zero_above;
        blank[0] = 1'b0;
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-digit enable,
// decimal points, leading-zero blanking and a dead cycle at each slot start.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter  int NUM_DIGITS = 8,
    parameter  int CLK_DIV    = 50000,
    localparam int CNT_W      = $clog2(CLK_DIV),
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n
);

    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
    logic                    blz_q, blz_d;
    logic [CNT_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    lit;

    seg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
        .hex   (hex_q),
        .blank (lz_blank)
    );

    always_comb begin
        hex_d   = hex_q;
        en_d    = en_q;
        dpm_d   = dpm_q;
        blz_d   = blz_q;
        presc_d = presc_q + CNT_W'(1);
        idx_d   = idx_q;
        an_n_d  = an_n_q;
        seg_n_d = seg_n_q;
        dp_n_d  = dp_n_q;

        if (load) begin
            hex_d = hex;
            en_d  = digit_en;
            dpm_d = dp;
            blz_d = blank_lz;
        end

        if (presc_q == CNT_W'(CLK_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        lit = en_q[idx_q] & ~(blz_q & lz_blank[idx_q]);

        // Digit data is sampled once per slot (prescaler==1) and then held,
        // so a load arriving mid-slot cannot tear the digit being shown.
        if (presc_q == '0) begin
            an_n_d  = '1;
            seg_n_d = SEG_BLANK;
            dp_n_d  = 1'b1;
        end else if (presc_q == CNT_W'(1)) begin
            an_n_d  = '1;
            seg_n_d = SEG_BLANK;
            dp_n_d  = 1'b1;
            if (lit) begin
                an_n_d[idx_q] = 1'b0;
                seg_n_d       = hex_to_seg(hex_q[{idx_q, 2'b00} +: 4]);
                dp_n_d        = ~dpm_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hex_q   <= '0;
            en_q    <= '0;
            dpm_q   <= '0;
            blz_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            an_n_q  <= '1;
            seg_n_q <= SEG_BLANK;
            dp_n_q  <= 1'b1;
        end else begin
            hex_q   <= hex_d;
            en_q    <= en_d;
            dpm_q   <= dpm_d;
            blz_q   <= blz_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_n_q  <= an_n_d;
            seg_n_q <= seg_n_d;
            dp_n_q  <= dp_n_d;
        end
    end

    assign an_n  = an_n_q;
    assign seg_n = seg_n_q;
    assign dp_n  = dp_n_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=8, CLK_DIV=4 (32-clk frame).
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] hex;
    logic [7:0]  digit_en;
    logic [7:0]  dp;
    logic        blank_lz;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    logic [31:0] nxt_hex;
    logic [7:0]  nxt_en;
    logic [7:0]  nxt_dp;
    logic        nxt_blz;

    int n_vec  = 0;
    int n_miss = 0;

    seg_scan_driver #(.NUM_DIGITS(8), .CLK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .hex      (hex),
        .digit_en (digit_en),
        .dp       (dp),
        .blank_lz (blank_lz),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n_edges clocks from a slot-0 boundary; slot k expects digit k.
    // lit[k]: anode k low; seg[7k+:7]: segment pattern; dpm[k]: point lit.
    task automatic run_frame(input string tag, input int ld_edge, input int n_edges,
                             input logic [7:0] lit, input logic [55:0] seg,
                             input logic [7:0] dpm);
        logic [7:0] ea;
        int k;
        for (int j = 0; j < n_edges; j++) begin
            if (j == ld_edge) begin
                hex      = nxt_hex;
                digit_en = nxt_en;
                dp       = nxt_dp;
                blank_lz = nxt_blz;
                load     = 1'b1;
            end
            tick();
            load = 1'b0;
            k  = j / 4;
            ea = 8'h01 << k;
            ea = ~ea;
            if (j % 4 == 0)
                check_eq($sformatf("%s dead slot%0d", tag, k), {16'h0, an_n, seg_n, dp_n},
                         {16'h0, 8'hFF, 7'h7F, 1'b1});
            else if (lit[k])
                check_eq($sformatf("%s lit slot%0d", tag, k), {16'h0, an_n, seg_n, dp_n},
                         {16'h0, ea, seg[k*7 +: 7], ~dpm[k]});
            else
                check_eq($sformatf("%s off slot%0d", tag, k), {24'h0, an_n}, {24'h0, 8'hFF});
        end
    endtask

    localparam logic [55:0] SEG_A5    = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12};
    localparam logic [55:0] SEG_ZERO0 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [55:0] SEG_MIX   = {7'h79, 7'h24, 7'h30, 7'h19, 7'h40, 7'h40, 7'h08, 7'h12};
    localparam logic [55:0] SEG_1TO8  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

    initial begin
        rst = 1'b1; load = 1'b0; hex = '0; digit_en = '0; dp = '0; blank_lz = 1'b0;
        nxt_hex = '0; nxt_en = '0; nxt_dp = '0; nxt_blz = 1'b0;

        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                hex = 32'h0000_00A5; digit_en = 8'hFF; load = 1'b1;
            end
            tick();
            check_eq($sformatf("reset cyc%0d", i), {16'h0, an_n, seg_n, dp_n},
                     {16'h0, 8'hFF, 7'h7F, 1'b1});
        end
        load = 1'b0;
        rst  = 1'b0;

        run_frame("en_off", -1, 32, 8'h00, SEG_A5, 8'h00);

        nxt_hex = 32'h0000_00A5; nxt_en = 8'hFF; nxt_dp = 8'h00; nxt_blz = 1'b0;
        run_frame("a5", 0, 32, 8'hFF, SEG_A5, 8'h00);

        nxt_blz = 1'b1;
        run_frame("a5_lz", 0, 32, 8'h03, SEG_A5, 8'h00);

        nxt_hex = 32'h0;
        run_frame("zero_lz", 0, 32, 8'h01, SEG_ZERO0, 8'h00);

        nxt_hex = 32'h0000_00A5; nxt_blz = 1'b0; nxt_dp = 8'h04; nxt_en = 8'hFB;
        run_frame("dp_en_off", 0, 32, 8'hFB, SEG_A5, 8'h00);

        nxt_en = 8'hFF;
        run_frame("dp_on", 0, 32, 8'hFF, SEG_A5, 8'h04);

        nxt_hex = 32'h1234_5678; nxt_dp = 8'h00;
        run_frame("midload", 14, 32, 8'hFF, SEG_MIX, 8'h04);

        run_frame("pre_rst", -1, 22, 8'hFF, SEG_1TO8, 8'h00);
        rst = 1'b1;
        tick();
        check_eq("midrst blank", {16'h0, an_n, seg_n, dp_n}, {16'h0, 8'hFF, 7'h7F, 1'b1});
        rst = 1'b0;

        nxt_hex = 32'h0000_00A5; nxt_en = 8'hFF; nxt_dp = 8'h00; nxt_blz = 1'b0;
        run_frame("post_rst", 0, 32, 8'hFF, SEG_A5, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
